// File: rtl/ofmap_packer.sv
`default_nettype none
// ============================================================================
// Module   : ofmap_packer
// Brief    : Output-feature-map writeback stage. Packs int8 results four per
//            32-bit word (little-endian), passes raw int32 partial sums whole,
//            buffers words in a small FIFO and drains them to DRAM over a
//            valid/ready handshake with an incrementing word address.
//            Optional macro OFMAP_PACKER_STALL_CNT_EN adds a saturating
//            16-bit back-pressure cycle counter on port stall_cnt.
// Revision : 1.0 - initial release
// ============================================================================
module ofmap_packer #(
    parameter int                DATA_SIZE  = 32,
    parameter int                FIFO_DEPTH = 8,
    parameter int                ADDR_W     = 12,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [DATA_SIZE-1:0] in_data,
    input  logic                 in_raw,
    input  logic                 done_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATA_SIZE-1:0] out_data,
    output logic [3:0]           out_strb,
    output logic [ADDR_W-1:0]    out_addr,
    output logic                 idle,
    output logic                 flushed,
    output logic                 overflow
`ifdef OFMAP_PACKER_STALL_CNT_EN
    ,
    output logic [15:0]          stall_cnt
`endif
);

    localparam int c_PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int c_CNT_W = c_PTR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t               r_state;
    logic                 r_flushed;
    logic                 r_overflow;
    logic [23:0]          r_part;      // bytes 0..2 of the word being packed
    logic [1:0]           r_bcnt;      // number of bytes held in r_part
    logic [DATA_SIZE-1:0] r_mem_data [FIFO_DEPTH];
    logic [3:0]           r_mem_strb [FIFO_DEPTH];
    logic [c_PTR_W-1:0]   r_wptr;
    logic [c_PTR_W-1:0]   r_rptr;
    logic [c_CNT_W-1:0]   r_fcnt;
    logic [ADDR_W-1:0]    r_addr;

    logic                 w_valid;
    logic                 w_pop;
    logic                 w_accept;
    logic                 w_late_in;
    logic                 w_fits;
    logic                 w_drop;
    logic                 w_push_any;
    logic                 w_store;
    logic [1:0]           w_need;
    logic [1:0]           w_npush;
    logic [c_CNT_W-1:0]   w_free;
    logic [DATA_SIZE-1:0] w_part_word;
    logic [3:0]           w_part_strb;
    logic [DATA_SIZE-1:0] w_d0;
    logic [DATA_SIZE-1:0] w_d1;
    logic [3:0]           w_s0;
    logic [3:0]           w_s1;
    logic [c_PTR_W-1:0]   w_wptr1;

    assign w_valid     = (r_fcnt != '0);
    assign w_pop       = w_valid && out_ready;
    assign w_accept    = in_valid && ((r_state == S_IDLE) || (r_state == S_RUN));
    assign w_late_in   = in_valid && ((r_state == S_FLUSH) || (r_state == S_DONE));
    // Free space is taken before this cycle's pop, so a full FIFO never
    // accepts a word even while the head is leaving.
    assign w_free      = c_CNT_W'(FIFO_DEPTH) - r_fcnt;
    assign w_part_word = DATA_SIZE'({8'h00, r_part});
    assign w_part_strb = (4'b0001 << r_bcnt) - 4'b0001;
    assign w_wptr1     = r_wptr + c_PTR_W'(1);

    // Decide which words (0, 1 or 2) this cycle wants to push and whether they fit
    always_comb begin
        w_need = 2'd0;
        w_d0   = '0;
        w_s0   = 4'b0000;
        w_d1   = '0;
        w_s1   = 4'b0000;
        if (w_accept) begin
            if (in_raw) begin
                if (r_bcnt != 2'd0) begin
                    // Partial word leaves first so DRAM order matches input order
                    w_need = 2'd2;
                    w_d0   = w_part_word;
                    w_s0   = w_part_strb;
                    w_d1   = in_data;
                    w_s1   = 4'b1111;
                end else begin
                    w_need = 2'd1;
                    w_d0   = in_data;
                    w_s0   = 4'b1111;
                end
            end else if (r_bcnt == 2'd3) begin
                w_need = 2'd1;
                w_d0   = DATA_SIZE'({in_data[7:0], r_part});
                w_s0   = 4'b1111;
            end
        end else if ((r_state == S_FLUSH) && (r_bcnt != 2'd0)) begin
            w_need = 2'd1;
            w_d0   = w_part_word;
            w_s0   = w_part_strb;
        end
        w_fits  = (c_CNT_W'(w_need) <= w_free);
        w_npush = w_fits ? w_need : 2'd0;
    end

    assign w_drop     = (w_need != 2'd0) && !w_fits;
    assign w_push_any = (w_npush != 2'd0);
    assign w_store    = w_accept && !in_raw && (r_bcnt != 2'd3);

    // Control FSM: IDLE/RUN accept data, FLUSH drains, DONE pulses flushed
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_flushed <= 1'b0;
        end else begin
            r_flushed <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (done_in) begin
                        r_state <= S_FLUSH;
                    end else if (in_valid) begin
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (done_in) begin
                        r_state <= S_FLUSH;
                    end
                end
                S_FLUSH: begin
                    if ((r_bcnt == 2'd0) && (r_fcnt == '0)) begin
                        r_state   <= S_DONE;
                        r_flushed <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Byte accumulator: store int8 lanes, clear whenever its contents are pushed
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bcnt <= 2'd0;
            r_part <= '0;
        end else if (w_push_any) begin
            r_bcnt <= 2'd0;
            r_part <= '0;
        end else if (w_store) begin
            case (r_bcnt)
                2'd0:    r_part[7:0]   <= in_data[7:0];
                2'd1:    r_part[15:8]  <= in_data[7:0];
                default: r_part[23:16] <= in_data[7:0];
            endcase
            r_bcnt <= r_bcnt + 2'd1;
        end
    end

    // FIFO storage: up to two consecutive entries written per cycle
    always_ff @(posedge clk) begin
        if (w_npush != 2'd0) begin
            r_mem_data[r_wptr] <= w_d0;
            r_mem_strb[r_wptr] <= w_s0;
        end
        if (w_npush == 2'd2) begin
            r_mem_data[w_wptr1] <= w_d1;
            r_mem_strb[w_wptr1] <= w_s1;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_fcnt <= '0;
        end else begin
            r_wptr <= r_wptr + c_PTR_W'(w_npush);
            if (w_pop) begin
                r_rptr <= r_rptr + c_PTR_W'(1);
            end
            r_fcnt <= r_fcnt + c_CNT_W'(w_npush) - c_CNT_W'(w_pop);
        end
    end

    // Head word address: advances per handshake, rewinds after a completed flush
    always_ff @(posedge clk) begin
        if (rst || (r_state == S_DONE)) begin
            r_addr <= BASE_ADDR;
        end else if (w_pop) begin
            r_addr <= r_addr + ADDR_W'(1);
        end
    end

    // Sticky overflow: dropped input or input arriving while flushing
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else if (w_drop || w_late_in) begin
            r_overflow <= 1'b1;
        end
    end

`ifdef OFMAP_PACKER_STALL_CNT_EN
    logic [15:0] r_stall_cnt;

    // Saturating count of back-pressured cycles, cleared when a flush completes
    always_ff @(posedge clk) begin
        if (rst || r_flushed) begin
            r_stall_cnt <= 16'h0000;
        end else if (w_valid && !out_ready && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'h0001;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

    // Head outputs are masked to zero while the FIFO is empty
    assign out_valid = w_valid;
    assign out_data  = w_valid ? r_mem_data[r_rptr] : '0;
    assign out_strb  = w_valid ? r_mem_strb[r_rptr] : 4'b0000;
    assign out_addr  = r_addr;
    assign idle      = (r_state == S_IDLE) && (r_fcnt == '0) && (r_bcnt == 2'd0);
    assign flushed   = r_flushed;
    assign overflow  = r_overflow;

endmodule
`default_nettype wire
